riscv_rf_dbg_seq: RTL and testbench

Sequencer granting the debug unit safe access to the integer register file. Accepts single read/write requests from the debug interface, stalls the pipeline, waits for in-flight writeback to drain, and drives the register file's debug port (du_we_rf/du_dato/du_addr, du_dati_rf). Sits between the debug unit and riscv_rf inside the core, and owns the stall request to the pipeline controller.

---
 rtl/riscv_rf_dbg_seq_if.sv | 43 ++++
 rtl/riscv_rf_dbg_seq.sv | 134 +++++++++++++
 tb/tb_riscv_rf_dbg_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_rf_dbg_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_rf_dbg_seq_if
// Description : Debug-request, pipeline-handshake and RF debug-port bundle
//               between the debug unit, the RF sequencer and riscv_rf.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_rf_dbg_seq_if #(
    parameter int XLEN = 32
);
    logic            req_i;
    logic            req_we_i;
    logic [11:0]     req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic            ack_o;
    logic            err_o;
    logic [XLEN-1:0] rdata_o;
    logic            busy_o;
    logic            stall_req_o;
    logic            du_stall_i;
    logic            pipe_we_i;
    logic            du_we_rf_o;
    logic [XLEN-1:0] du_dato_o;
    logic [11:0]     du_addr_o;
    logic [XLEN-1:0] du_dati_rf_i;

    // The sequencer side
    modport slave (
        input  req_i, req_we_i, req_addr_i, req_wdata_i,
        input  du_stall_i, pipe_we_i, du_dati_rf_i,
        output ack_o, err_o, rdata_o, busy_o, stall_req_o,
        output du_we_rf_o, du_dato_o, du_addr_o
    );

    // Debug unit / pipeline / RF side
    modport master (
        output req_i, req_we_i, req_addr_i, req_wdata_i,
        output du_stall_i, pipe_we_i, du_dati_rf_i,
        input  ack_o, err_o, rdata_o, busy_o, stall_req_o,
        input  du_we_rf_o, du_dato_o, du_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/riscv_rf_dbg_seq.sv
`default_nettype none
// ============================================================================
// Module      : riscv_rf_dbg_seq
// Description : Sequences a single debug read/write of the integer RF:
//               stall the pipeline, drain writeback, then use the RF debug port.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_rf_dbg_seq #(
    parameter int XLEN    = 32,
    parameter int AR_BITS = 5,
    parameter int TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    riscv_rf_dbg_seq_if.slave bus
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT     = 2'd1;
    localparam logic [1:0] c_ACCESS   = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [7:0]      r_cnt;
    logic            r_we;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_wdata;
    logic            r_ack;
    logic            r_err;
    logic            r_busy;
    logic            r_stall;
    logic            r_we_rf;
    logic [XLEN-1:0] r_rdata;
    logic            w_addr_ok;
    logic            w_idx_zero;
    logic            w_go;
    logic            w_tmo;
    logic            w_err_nxt;

    generate
        if (AR_BITS < 12) begin : g_addr_chk
            assign w_addr_ok = (bus.req_addr_i[11:AR_BITS] == '0);
        end else begin : g_addr_all
            assign w_addr_ok = 1'b1;
        end
    endgenerate

    assign w_idx_zero = (r_addr[AR_BITS-1:0] == '0);
    assign w_go       = bus.du_stall_i & ~bus.pipe_we_i;
    assign w_tmo      = (r_cnt == c_TMO_LAST);

    // Drain condition is checked before the timeout so a last-cycle drain still commits
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.req_i) begin
                    if (w_addr_ok) begin
                        w_state_nxt = c_WAIT;
                    end else begin
                        w_state_nxt = c_DONE;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            c_WAIT: begin
                if (w_go) begin
                    w_state_nxt = c_ACCESS;
                end else if (w_tmo) begin
                    w_state_nxt = c_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            c_ACCESS: w_state_nxt = c_DONE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_stall <= 1'b0;
            r_we_rf <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_IDLE);
            r_ack   <= (w_state_nxt == c_DONE);
            r_err   <= w_err_nxt;
            // An invalid address goes IDLE->DONE and must never touch the pipeline
            r_stall <= (w_state_nxt == c_WAIT) || (w_state_nxt == c_ACCESS) ||
                       ((w_state_nxt == c_DONE) && (r_state != c_IDLE));
            // Only reachable from WAIT, i.e. after pipe_we_i was seen low
            r_we_rf <= (w_state_nxt == c_ACCESS) && r_we && !w_idx_zero;

            if ((r_state == c_WAIT) && (w_state_nxt == c_WAIT)) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= '0;
            end

            if ((r_state == c_IDLE) && bus.req_i) begin
                r_we    <= bus.req_we_i;
                r_addr  <= bus.req_addr_i;
                r_wdata <= bus.req_wdata_i;
            end

            if ((r_state == c_ACCESS) && !r_we) begin
                r_rdata <= w_idx_zero ? '0 : bus.du_dati_rf_i;
            end
        end
    end

    assign bus.ack_o       = r_ack;
    assign bus.err_o       = r_err;
    assign bus.rdata_o     = r_rdata;
    assign bus.busy_o      = r_busy;
    assign bus.stall_req_o = r_stall;
    assign bus.du_we_rf_o  = r_we_rf;
    assign bus.du_dato_o   = r_wdata;
    assign bus.du_addr_o   = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_riscv_rf_dbg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_rf_dbg_seq
// Description : Table-driven bench for riscv_rf_dbg_seq with an RF model and
//               a result scoreboard. Revision 1.0 - initial release
// ============================================================================
module tb_riscv_rf_dbg_seq;

    logic clk;
    logic rstn;

    riscv_rf_dbg_seq_if #(.XLEN(32)) bus ();

    riscv_rf_dbg_seq #(
        .XLEN    (32),
        .AR_BITS (5),
        .TIMEOUT (16)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: write on clock, combinational read
    logic [31:0] rf_mem [32];
    logic [31:0] exp_rf [32];
    always @(posedge clk) begin
        if (bus.du_we_rf_o) rf_mem[bus.du_addr_o[4:0]] <= bus.du_dato_o;
    end
    assign bus.du_dati_rf_i = rf_mem[bus.du_addr_o[4:0]];

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          sdly;
        int          pcyc;
        bit          drop;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          exp_wr;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } sb_t;

    sb_t  sb_q [$];
    vec_t tbl [12];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                                input int sdly, input int pcyc, input bit drop, input logic exp_err,
                                input int exp_lat, input logic [31:0] exp_rdata, input int exp_wr);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.sdly = sdly; v.pcyc = pcyc; v.drop = drop;
        v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_rdata = exp_rdata; v.exp_wr = exp_wr;
        return v;
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge of the following IDLE cycle
    task automatic do_req(input string tag, input vec_t v);
        sb_t e;
        sb_t got_e;
        bit  got;
        bit  valid;
        int  lat;
        int  pulses;
        int  bad_we;
        int  bad_prof;
        valid = (v.addr[11:5] == 7'd0);
        bus.req_i       = 1'b1;
        bus.req_we_i    = v.we;
        bus.req_addr_i  = v.addr;
        bus.req_wdata_i = v.wdata;
        bus.du_stall_i  = (v.sdly == 0);
        bus.pipe_we_i   = (v.pcyc > 0);
        e.err   = v.exp_err;
        e.rdata = v.exp_rdata;
        sb_q.push_back(e);
        got = 0; lat = 0; pulses = 0; bad_we = 0; bad_prof = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            bus.du_stall_i = (c >= v.sdly);
            bus.pipe_we_i  = (c < v.pcyc);
            if (v.drop) bus.req_i = 1'b0;
            if (bus.stall_req_o !== (valid && c <= v.exp_lat) || bus.busy_o !== (c <= v.exp_lat))
                bad_prof++;
            if (bus.du_we_rf_o === 1'b1) begin
                pulses++;
                if (c != v.exp_lat - 1 || bus.du_addr_o !== v.addr || bus.du_dato_o !== v.wdata)
                    bad_we++;
            end
            if (bus.ack_o === 1'b1) begin
                got = 1;
                lat = c;
                bus.req_i = 1'b0;
                if (sb_q.size() == 0) begin
                    check({tag, "_sb_empty"}, 64'd1, 64'd0);
                end else begin
                    got_e = sb_q.pop_front();
                    check({tag, "_err"}, 64'(bus.err_o), 64'(got_e.err));
                    check({tag, "_rdata"}, 64'(bus.rdata_o), 64'(got_e.rdata));
                end
            end
        end
        if (!got) begin
            bus.req_i = 1'b0;
            void'(sb_q.pop_front());
        end
        check({tag, "_ack_latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, "_rf_we_pulses"}, 64'(pulses), 64'(v.exp_wr));
        check({tag, "_rf_we_timing"}, 64'(bad_we), 64'd0);
        check({tag, "_stall_busy_profile"}, 64'(bad_prof), 64'd0);
        @(negedge clk);
        check({tag, "_idle_after"}, 64'({bus.ack_o, bus.busy_o, bus.stall_req_o}), 64'd0);
        if (v.exp_wr != 0) exp_rf[v.addr[4:0]] = v.wdata;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'd0;
            exp_rf[i] = 32'd0;
        end
        rf_mem[5] = 32'hDEAD_BEEF;
        exp_rf[5] = 32'hDEAD_BEEF;

        //            we    addr     wdata          sdly pcyc drop err lat rdata         wr
        tbl[0]  = mk(1'b0, 12'h005, 32'h0,          0,   0,   0, 1'b0, 3, 32'hDEAD_BEEF, 0);
        tbl[1]  = mk(1'b1, 12'h00A, 32'h1234_5678,  0,   5,   0, 1'b0, 7, 32'hDEAD_BEEF, 1);
        tbl[2]  = mk(1'b1, 12'h000, 32'hFFFF_FFFF,  0,   0,   0, 1'b0, 3, 32'hDEAD_BEEF, 0);
        tbl[3]  = mk(1'b0, 12'h000, 32'h0,          0,   0,   0, 1'b0, 3, 32'h0,         0);
        tbl[4]  = mk(1'b0, 12'h7B0, 32'h0,          0,   0,   0, 1'b1, 1, 32'h0,         0);
        tbl[5]  = mk(1'b0, 12'h00A, 32'h0,          200, 0,   0, 1'b1, 17, 32'h0,        0);
        tbl[6]  = mk(1'b0, 12'h00A, 32'h0,          3,   2,   0, 1'b0, 5, 32'h1234_5678, 0);
        tbl[7]  = mk(1'b1, 12'h020, 32'h5555_5555,  0,   0,   0, 1'b1, 1, 32'h1234_5678, 0);
        tbl[8]  = mk(1'b1, 12'h01F, 32'hA5A5_A5A5,  16,  0,   0, 1'b0, 18, 32'h1234_5678, 1);
        tbl[9]  = mk(1'b0, 12'h01F, 32'h0,          0,   0,   1, 1'b0, 3, 32'hA5A5_A5A5, 0);
        tbl[10] = mk(1'b1, 12'h01F, 32'h0BAD_0BAD,  17,  0,   0, 1'b1, 17, 32'hA5A5_A5A5, 0);
        tbl[11] = mk(1'b0, 12'h01F, 32'h0,          0,   0,   0, 1'b0, 3, 32'hA5A5_A5A5, 0);

        rstn = 1'b0;
        bus.req_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
        bus.du_stall_i = 1'b1; bus.pipe_we_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack",   64'(bus.ack_o),       64'd0);
        check("rst_err",   64'(bus.err_o),       64'd0);
        check("rst_busy",  64'(bus.busy_o),      64'd0);
        check("rst_stall", 64'(bus.stall_req_o), 64'd0);
        check("rst_we_rf", 64'(bus.du_we_rf_o),  64'd0);
        check("rst_rdata", 64'(bus.rdata_o),     64'd0);
        check("rst_dato",  64'(bus.du_dato_o),   64'd0);
        check("rst_addr",  64'(bus.du_addr_o),   64'd0);
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_req($sformatf("row%0d", i), tbl[i]);
        end

        // Reset while a write is stalled in WAIT: the access must vanish
        bus.req_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 12'h007;
        bus.req_wdata_i = 32'h0BAD_F00D; bus.du_stall_i = 1'b0; bus.pipe_we_i = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_waiting", 64'({bus.busy_o, bus.stall_req_o, bus.ack_o}), 64'b110);
        rstn = 1'b0;
        bus.req_i = 1'b0;
        @(negedge clk);
        check("midrst_ctrl",  64'({bus.ack_o, bus.err_o, bus.busy_o, bus.stall_req_o, bus.du_we_rf_o}), 64'd0);
        check("midrst_rdata", 64'(bus.rdata_o),   64'd0);
        check("midrst_dato",  64'(bus.du_dato_o), 64'd0);
        check("midrst_addr",  64'(bus.du_addr_o), 64'd0);
        rstn = 1'b1;
        bus.du_stall_i = 1'b1;
        @(negedge clk);
        check("midrst_no_ack", 64'(bus.ack_o), 64'd0);
        do_req("post_rst_read", mk(1'b0, 12'h005, 32'h0, 0, 0, 0, 1'b0, 3, 32'hDEAD_BEEF, 0));

        check("rf_x0",  64'(rf_mem[0]),  64'(exp_rf[0]));
        check("rf_x5",  64'(rf_mem[5]),  64'(exp_rf[5]));
        check("rf_x7",  64'(rf_mem[7]),  64'(exp_rf[7]));
        check("rf_x10", 64'(rf_mem[10]), 64'(exp_rf[10]));
        check("rf_x31", 64'(rf_mem[31]), 64'(exp_rf[31]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
